// File: rtl/cmd_sender_pkg.sv
// Shared constants and helpers for the framed command sender.
package cmd_sender_pkg;

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StWaitReady = 3'd1;
  localparam logic [2:0] StRequest   = 3'd2;
  localparam logic [2:0] StSend      = 3'd3;
  localparam logic [2:0] StWaitDone  = 3'd4;
  localparam logic [2:0] StDone      = 3'd5;

  localparam logic [7:0] HdrByteDefault = 8'hA5;

  function automatic int unsigned payload_bytes(input int unsigned cmd_w);
    return (cmd_w + 7) / 8;
  endfunction

  function automatic int unsigned frame_len(input int unsigned cmd_w);
    return payload_bytes(cmd_w) + 2;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with first-word-visible read and an occupancy count.
module cmd_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [LVL_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == LVL_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rptr_q];
  assign level_o = cnt_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + LVL_W'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - LVL_W'(1);
    end
  end

endmodule

// File: rtl/cmd_frame_sender.sv
// Queues host commands and sends each as a header/seq/payload frame over the
// UDP application TX handshake, retrying on ack timeout.
module cmd_frame_sender
  import cmd_sender_pkg::*;
#(
  parameter int unsigned CMD_W       = 2,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [7:0]  HDR_BYTE    = HdrByteDefault,
  parameter int unsigned ACK_TIMEOUT = 1024,
  parameter int unsigned MAX_RETRY   = 3,
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk_50,
  input  logic             sys_rst,
  input  logic [CMD_W-1:0] cmd_in,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic [LVL_W-1:0] fifo_level,
  output logic             busy,
  output logic             tx_done,
  output logic             tx_err,
  output logic [7:0]       tx_seq,
  input  logic             udp_tx_ready,
  input  logic             app_tx_ack,
  output logic             app_tx_data_request,
  output logic             app_tx_data_valid,
  output logic [7:0]       app_tx_data,
  output logic [15:0]      udp_data_length
);

  localparam int unsigned PAYLOAD_BYTES = payload_bytes(CMD_W);
  localparam int unsigned FRAME_LEN     = frame_len(CMD_W);
  localparam int unsigned PAY_W         = PAYLOAD_BYTES * 8;
  localparam int unsigned IDX_W         = $clog2(FRAME_LEN + 1);
  localparam int unsigned TMR_W         = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned RTY_W         = $clog2(MAX_RETRY + 2);

  logic [2:0]       state_q, state_d;
  logic [CMD_W-1:0] shadow_q, shadow_d;
  logic [7:0]       seq_q, seq_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [RTY_W-1:0] rty_q, rty_d;
  logic             first_q, first_d;
  logic             req_q, req_d;
  logic             valid_q, valid_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [7:0]       tx_seq_q, tx_seq_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CMD_W-1:0] fifo_rdata;
  logic [IDX_W-1:0] sel_idx, shift;
  logic [7:0]       frame_byte;

  assign cmd_ready = !fifo_full && !sys_rst;
  assign fifo_push = cmd_valid && cmd_ready;
  assign fifo_pop  = (state_q == StIdle) && !fifo_empty;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_50),
    .rst_i   (sys_rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (cmd_in),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Byte 0 is loaded on the ack edge, later bytes from the running index.
  assign sel_idx = (state_q == StSend) ? idx_q : '0;
  assign shift   = IDX_W'(FRAME_LEN - 1) - sel_idx;

  always_comb begin
    frame_byte = 8'(PAY_W'(shadow_q) >> {shift, 3'b000});
    if (sel_idx == '0)               frame_byte = HDR_BYTE;
    else if (sel_idx == IDX_W'(1))   frame_byte = seq_q;
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    seq_d    = seq_q;
    idx_d    = idx_q;
    tmr_d    = tmr_q;
    rty_d    = rty_q;
    first_d  = first_q;
    req_d    = req_q;
    valid_d  = valid_q;
    data_d   = data_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    tx_seq_d = tx_seq_q;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          shadow_d = fifo_rdata;
          state_d  = StWaitReady;
        end
      end
      StWaitReady: begin
        tmr_d = '0;
        if (udp_tx_ready) begin
          req_d   = 1'b1;
          state_d = StRequest;
        end
      end
      StRequest: begin
        // Ack is checked first so it wins over a coincident timeout.
        if (app_tx_ack) begin
          req_d   = 1'b0;
          valid_d = 1'b1;
          data_d  = frame_byte;
          idx_d   = IDX_W'(1);
          state_d = StSend;
        end else if (tmr_q == TMR_W'(ACK_TIMEOUT - 1)) begin
          req_d = 1'b0;
          if (rty_q < RTY_W'(MAX_RETRY)) begin
            rty_d   = rty_q + RTY_W'(1);
            state_d = StWaitReady;
          end else begin
            err_d    = 1'b1;
            tx_seq_d = seq_q;
            rty_d    = '0;
            state_d  = StIdle;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      StSend: begin
        if (idx_q == IDX_W'(FRAME_LEN)) begin
          valid_d = 1'b0;
          data_d  = '0;
          first_d = 1'b1;
          state_d = StWaitDone;
        end else begin
          data_d = frame_byte;
          idx_d  = idx_q + IDX_W'(1);
        end
      end
      StWaitDone: begin
        first_d = 1'b0;
        if (!first_q && udp_tx_ready) begin
          done_d   = 1'b1;
          tx_seq_d = seq_q;
          state_d  = StDone;
        end
      end
      StDone: begin
        seq_d   = seq_q + 8'd1;
        rty_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_50 or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      seq_q    <= '0;
      idx_q    <= '0;
      tmr_q    <= '0;
      rty_q    <= '0;
      first_q  <= 1'b0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tx_seq_q <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      seq_q    <= seq_d;
      idx_q    <= idx_d;
      tmr_q    <= tmr_d;
      rty_q    <= rty_d;
      first_q  <= first_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      done_q   <= done_d;
      err_q    <= err_d;
      tx_seq_q <= tx_seq_d;
    end
  end

  assign busy                = (state_q != StIdle);
  assign tx_done             = done_q;
  assign tx_err              = err_q;
  assign tx_seq              = tx_seq_q;
  assign app_tx_data_request = req_q;
  assign app_tx_data_valid   = valid_q;
  assign app_tx_data         = data_q;
  assign udp_data_length     = 16'(FRAME_LEN);

endmodule

// File: tb/tb_cmd_frame_sender.sv
// Directed bench for cmd_frame_sender: a 2-bit/16-cycle-timeout instance and a
// 12-bit instance, each driven by a small transport-core model.
module tb_cmd_frame_sender;

  logic clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;
  logic sys_rst;

  // Instance A: CMD_W=2, ACK_TIMEOUT=16
  logic [1:0]  cmd_a;
  logic        valid_a, ready_a, busy_a, done_a, err_a, rdy_a, ack_a, req_a, dv_a;
  logic [3:0]  level_a;
  logic [7:0]  seq_a, data_a;
  logic [15:0] len_a;

  cmd_frame_sender #(.CMD_W(2), .ACK_TIMEOUT(16)) dut_a (
    .clk_50(clk_50), .sys_rst(sys_rst), .cmd_in(cmd_a), .cmd_valid(valid_a),
    .cmd_ready(ready_a), .fifo_level(level_a), .busy(busy_a), .tx_done(done_a),
    .tx_err(err_a), .tx_seq(seq_a), .udp_tx_ready(rdy_a), .app_tx_ack(ack_a),
    .app_tx_data_request(req_a), .app_tx_data_valid(dv_a), .app_tx_data(data_a),
    .udp_data_length(len_a)
  );

  // Instance B: CMD_W=12
  logic [11:0] cmd_b;
  logic        valid_b, ready_b, busy_b, done_b, err_b, ack_b, req_b, dv_b;
  logic [3:0]  level_b;
  logic [7:0]  seq_b, data_b;
  logic [15:0] len_b;

  cmd_frame_sender #(.CMD_W(12)) dut_b (
    .clk_50(clk_50), .sys_rst(sys_rst), .cmd_in(cmd_b), .cmd_valid(valid_b),
    .cmd_ready(ready_b), .fifo_level(level_b), .busy(busy_b), .tx_done(done_b),
    .tx_err(err_b), .tx_seq(seq_b), .udp_tx_ready(1'b1), .app_tx_ack(ack_b),
    .app_tx_data_request(req_b), .app_tx_data_valid(dv_b), .app_tx_data(data_b),
    .udp_data_length(len_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transport model and monitor for A, sampled 1 ns after each rising edge.
  logic [7:0] bytes_a[$];
  logic [7:0] dseq_a[$];
  int done_cnt = 0, err_cnt = 0, done_hi = 0, err_hi = 0, err_seq = 0;
  int req_rises = 0, req_hi = 0, attempts = 0, req_cnt = 0;
  int ack_attempt = 1;
  logic req_prev = 1'b0;

  initial begin
    ack_a = 1'b0;
    forever begin
      @(posedge clk_50);
      #1;
      ack_a = 1'b0;
      if (req_a) begin
        if (!req_prev) begin
          attempts++;
          req_rises++;
          req_cnt = 0;
        end
        req_cnt++;
        req_hi++;
        if (attempts >= ack_attempt && req_cnt == 2) ack_a = 1'b1;
      end
      req_prev = req_a;
      if (dv_a) bytes_a.push_back(data_a);
      if (done_a) begin
        done_cnt++;
        done_hi++;
        dseq_a.push_back(seq_a);
        attempts = 0;
      end
      if (err_a) begin
        err_cnt++;
        err_hi++;
        err_seq = int'(seq_a);
        attempts = 0;
      end
    end
  end

  logic [7:0] bytes_b[$];
  int done_b_cnt = 0;

  initial begin
    ack_b = 1'b0;
    forever begin
      @(posedge clk_50);
      #1;
      ack_b = req_b;
      if (dv_b) bytes_b.push_back(data_b);
      if (done_b) done_b_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic push_a(input logic [1:0] v);
    int n = 0;
    while (!ready_a && n < 1000) begin
      @(negedge clk_50);
      n++;
    end
    valid_a = 1'b1;
    cmd_a   = v;
    @(negedge clk_50);
    valid_a = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk_50);
      n++;
    end
    check_eq(tag, done_cnt, target);
  endtask

  task automatic reset_dut();
    @(negedge clk_50);
    sys_rst = 1'b1;
    repeat (3) @(negedge clk_50);
    sys_rst = 1'b0;
    @(negedge clk_50);
  endtask

  initial begin
    int d0, e0, r0, h0, eh0, bad, n;
    sys_rst = 1'b1;
    cmd_a = '0; valid_a = 1'b0; rdy_a = 1'b1;
    cmd_b = '0; valid_b = 1'b0;
    repeat (3) @(negedge clk_50);
    check_eq("rst_cmd_ready", ready_a, 0);
    check_eq("rst_len", len_a, 3);
    check_eq("rst_outs", {busy_a, done_a, err_a, req_a, dv_a}, 0);
    check_eq("rst_data_seq_lvl", {data_a, seq_a, level_a}, 0);
    sys_rst = 1'b0;
    @(negedge clk_50);
    check_eq("cmd_ready_after_rst", ready_a, 1);

    // 1: single 2-bit command; request in the 3rd cycle after the push cycle
    push_a(2'b10);
    @(negedge clk_50);
    check_eq("lat_cycle2_req", req_a, 0);
    @(negedge clk_50);
    check_eq("lat_cycle3_req", req_a, 1);
    wait_done("t1_done", 1, 50);
    check_eq("t1_nbytes", bytes_a.size(), 3);
    if (bytes_a.size() == 3) begin
      check_eq("t1_b0", bytes_a[0], 8'hA5);
      check_eq("t1_b1", bytes_a[1], 8'h00);
      check_eq("t1_b2", bytes_a[2], 8'h02);
    end
    check_eq("t1_tx_seq", seq_a, 0);
    check_eq("t1_done_width", done_hi, 1);

    // 2: 12-bit command framed MSB first
    @(negedge clk_50);
    valid_b = 1'b1;
    cmd_b   = 12'hABC;
    @(negedge clk_50);
    valid_b = 1'b0;
    n = 0;
    while (done_b_cnt < 1 && n < 50) begin
      @(negedge clk_50);
      n++;
    end
    check_eq("t2_done", done_b_cnt, 1);
    check_eq("t2_len", len_b, 4);
    check_eq("t2_nbytes", bytes_b.size(), 4);
    if (bytes_b.size() == 4)
      check_eq("t2_bytes", {bytes_b[0], bytes_b[1], bytes_b[2], bytes_b[3]}, 32'hA5000ABC);

    // 3: fill the FIFO while the core is not ready, then drain in order
    reset_dut();
    bytes_a.delete();
    dseq_a.delete();
    d0 = done_cnt;
    rdy_a = 1'b0;
    for (int i = 0; i < 9; i++) begin
      valid_a = 1'b1;
      cmd_a   = 2'(i);
      @(negedge clk_50);
    end
    valid_a = 1'b0;
    check_eq("t3_full_ready", ready_a, 0);
    check_eq("t3_level", level_a, 8);
    check_eq("t3_busy", busy_a, 1);
    rdy_a = 1'b1;
    wait_done("t3_done", d0 + 9, 400);
    check_eq("t3_nbytes", bytes_a.size(), 27);
    if (bytes_a.size() == 27 && dseq_a.size() == 9) begin
      for (int k = 0; k < 9; k++) begin
        check_eq($sformatf("t3_f%0d_seq", k), bytes_a[3*k+1], k);
        check_eq($sformatf("t3_f%0d_pay", k), bytes_a[3*k+2], k % 4);
        check_eq($sformatf("t3_f%0d_txseq", k), dseq_a[k], k);
      end
    end

    // 4: never acked -> 4 windows of 16 cycles, drop with seq 9
    ack_attempt = 99;
    r0 = req_rises; h0 = req_hi; e0 = err_cnt; eh0 = err_hi; d0 = done_cnt;
    push_a(2'd1);
    n = 0;
    while (err_cnt == e0 && n < 200) begin
      @(negedge clk_50);
      n++;
    end
    check_eq("t4_err", err_cnt - e0, 1);
    check_eq("t4_err_width", err_hi - eh0, 1);
    check_eq("t4_rises", req_rises - r0, 4);
    check_eq("t4_req_cycles", req_hi - h0, 64);
    check_eq("t4_err_seq", err_seq, 9);
    check_eq("t4_no_done", done_cnt - d0, 0);
    ack_attempt = 1;
    bytes_a.delete();
    push_a(2'd3);
    wait_done("t4_next_done", d0 + 1, 50);
    if (bytes_a.size() == 3)
      check_eq("t4_next_frame", {bytes_a[1], bytes_a[2]}, 16'h0903);
    check_eq("t4_next_txseq", seq_a, 9);

    // 5: ack on the third attempt
    ack_attempt = 3;
    r0 = req_rises; e0 = err_cnt; d0 = done_cnt;
    bytes_a.delete();
    push_a(2'd2);
    wait_done("t5_done", d0 + 1, 200);
    check_eq("t5_rises", req_rises - r0, 3);
    check_eq("t5_no_err", err_cnt - e0, 0);
    check_eq("t5_nbytes", bytes_a.size(), 3);
    if (bytes_a.size() == 3)
      check_eq("t5_frame", {bytes_a[0], bytes_a[1], bytes_a[2]}, 24'hA50A02);
    ack_attempt = 1;

    // 6a: 258 frames, sequence wraps 255 -> 0
    reset_dut();
    bytes_a.delete();
    dseq_a.delete();
    d0 = done_cnt;
    for (int k = 0; k < 258; k++) push_a(2'(k));
    wait_done("t6_done", d0 + 258, 5000);
    bad = 0;
    if (dseq_a.size() == 258 && bytes_a.size() == 774) begin
      for (int k = 0; k < 258; k++)
        if (dseq_a[k] != 8'(k) || bytes_a[3*k+1] != 8'(k) || bytes_a[3*k+2] != 8'(k % 4))
          bad++;
      check_eq("t6_seq255", dseq_a[255], 8'd255);
      check_eq("t6_seq_wrap", dseq_a[256], 8'd0);
    end else begin
      bad = 1;
    end
    check_eq("t6_order_bad", bad, 0);
    check_eq("t6_tx_seq", seq_a, 1);

    // 6b: reset in the middle of SEND
    push_a(2'd1);
    push_a(2'd2);
    push_a(2'd3);
    n = 0;
    while (!dv_a && n < 50) begin
      @(negedge clk_50);
      n++;
    end
    check_eq("t6_in_send", dv_a, 1);
    check_eq("t6_level_pre", level_a, 2);
    d0 = done_cnt; e0 = err_cnt; r0 = req_rises;
    sys_rst = 1'b1;
    #1;
    check_eq("t6_rst_outs", {busy_a, done_a, err_a, req_a, dv_a, ready_a}, 0);
    check_eq("t6_rst_data_seq_lvl", {data_a, seq_a, level_a}, 0);
    check_eq("t6_rst_len", len_a, 3);
    repeat (2) @(negedge clk_50);
    sys_rst = 1'b0;
    repeat (20) @(negedge clk_50);
    check_eq("t6_no_done", done_cnt - d0, 0);
    check_eq("t6_no_err", err_cnt - e0, 0);
    check_eq("t6_no_request", req_rises - r0, 0);
    check_eq("t6_level_post", level_a, 0);
    check_eq("t6_ready_post", ready_a, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
